// File: rtl/data_mem_sync.sv
// DEPTH x DW data memory: one write port, two registered read ports, sequential zero-fill.
// Optional macro DMEM_BYPASS_EN selects write-first forwarding; undefined gives read-first.
module data_mem_sync #(
   parameter int DW    = 8,
   parameter int AW    = 8,
   parameter int DEPTH = 1 << AW
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          WriteEn,
   input  logic [AW-1:0] WriteAddr,
   input  logic [DW-1:0] DataIn,
   input  logic [AW-1:0] ReadAddrA,
   input  logic [AW-1:0] ReadAddrB,
   output logic [DW-1:0] DataOutA,
   output logic [DW-1:0] DataOutB,
   output logic          Busy,
   output logic          WrDropped
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0] LAST_C  = DEPTH_C - 1'b1;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   clr_ptr_q, clr_ptr_d;
   logic [DW-1:0] dout_a_q, dout_a_d;
   logic [DW-1:0] dout_b_q, dout_b_d;
   logic          wr_drop_q, wr_drop_d;

   logic          core_we;
   logic [IW-1:0] core_waddr;
   logic [DW-1:0] core_wdata;
   logic          wr_in_range, rd_a_in_range, rd_b_in_range, wr_accept;

   logic [DW-1:0] core [DEPTH];

   assign wr_in_range   = ({1'b0, WriteAddr} < DEPTH_C);
   assign rd_a_in_range = ({1'b0, ReadAddrA} < DEPTH_C);
   assign rd_b_in_range = ({1'b0, ReadAddrB} < DEPTH_C);
   assign wr_accept     = !Reset && (state_q == IDLE) && WriteEn && wr_in_range;

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      core_we    = 1'b0;
      core_waddr = clr_ptr_q[IW-1:0];
      core_wdata = '0;
      dout_a_d   = '0;
      dout_b_d   = '0;
      wr_drop_d  = 1'b0;
      if (!Reset) begin
         if (state_q == CLEAR) begin
            // One word zeroed per edge; user writes are refused and flagged.
            core_we   = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            wr_drop_d = WriteEn;
            if (clr_ptr_q == LAST_C) begin
               state_d = IDLE;
            end
         end else begin
            core_we    = wr_accept;
            core_waddr = WriteAddr[IW-1:0];
            core_wdata = DataIn;
            wr_drop_d  = WriteEn && !wr_in_range;
            if (rd_a_in_range) begin
               dout_a_d = core[ReadAddrA[IW-1:0]];
            end
            if (rd_b_in_range) begin
               dout_b_d = core[ReadAddrB[IW-1:0]];
            end
`ifdef DMEM_BYPASS_EN
            // wr_accept already guarantees WriteAddr (and thus an equal read address) is in range.
            if (wr_accept && (ReadAddrA == WriteAddr)) begin
               dout_a_d = DataIn;
            end
            if (wr_accept && (ReadAddrB == WriteAddr)) begin
               dout_b_d = DataIn;
            end
`endif
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         dout_a_q  <= '0;
         dout_b_q  <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         dout_a_q  <= dout_a_d;
         dout_b_q  <= dout_b_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Core kept free of reset so it can map onto block RAM.
   always_ff @(posedge Clk) begin
      if (core_we) begin
         core[core_waddr] <= core_wdata;
      end
   end

   assign DataOutA  = dout_a_q;
   assign DataOutB  = dout_b_q;
   assign WrDropped = wr_drop_q;
   assign Busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: a 256-word and a 200-word instance share one stimulus stream.
// Expected outputs come from an array-based memory model with a clear countdown.
module tb_data_mem_sync;

   localparam int DW = 8;
   localparam int AW = 8;
`ifdef DMEM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          Clk = 1'b0;
   logic          Reset;
   logic          WriteEn;
   logic [AW-1:0] WriteAddr, ReadAddrA, ReadAddrB;
   logic [DW-1:0] DataIn;
   logic [DW-1:0] a0, b0, a1, b1;
   logic          busy0, busy1, drop0, drop1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   data_mem_sync #(.DW(DW), .AW(AW), .DEPTH(256)) dut (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
      .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .DataOutA(a0), .DataOutB(b0),
      .Busy(busy0), .WrDropped(drop0)
   );

   data_mem_sync #(.DW(DW), .AW(AW), .DEPTH(200)) dut2 (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
      .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .DataOutA(a1), .DataOutB(b1),
      .Busy(busy1), .WrDropped(drop1)
   );

   // Reference model: remaining clear edges per instance, plus plain word arrays.
   int         depth [2] = '{256, 200};
   int         rem   [2];
   logic [7:0] mem   [2][256];
   logic [7:0] ea    [2];
   logic [7:0] eb    [2];
   logic       ed    [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_read(input int i, input int ra, input bit acc);
      if (ra >= depth[i]) return 8'h00;
      if (BYP && acc && (ra == int'(WriteAddr))) return DataIn;
      return mem[i][ra];
   endfunction

   task automatic model_edge();
      bit acc;
      for (int i = 0; i < 2; i++) begin
         if (Reset) begin
            rem[i] = depth[i];
            ea[i] = 8'h00; eb[i] = 8'h00; ed[i] = 1'b0;
         end else if (rem[i] > 0) begin
            ea[i] = 8'h00; eb[i] = 8'h00; ed[i] = WriteEn;
            rem[i]--;
            if (rem[i] == 0) begin
               for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
            end
         end else begin
            acc   = WriteEn && (int'(WriteAddr) < depth[i]);
            ed[i] = WriteEn && !acc;
            ea[i] = exp_read(i, int'(ReadAddrA), acc);
            eb[i] = exp_read(i, int'(ReadAddrB), acc);
            if (acc) mem[i][WriteAddr] = DataIn;
         end
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge Clk);
      #1;
      chk("busy0", 32'(busy0), 32'(rem[0] > 0));
      chk("busy1", 32'(busy1), 32'(rem[1] > 0));
      chk("dropA0", 32'(drop0), 32'(ed[0]));
      chk("drop1", 32'(drop1), 32'(ed[1]));
      chk("doutA0", 32'(a0), 32'(ea[0]));
      chk("doutB0", 32'(b0), 32'(eb[0]));
      chk("doutA1", 32'(a1), 32'(ea[1]));
      chk("doutB1", 32'(b1), 32'(eb[1]));
   endtask

   task automatic set_in(input logic we, input logic [7:0] wa, input logic [7:0] d,
                         input logic [7:0] ra, input logic [7:0] rb);
      WriteEn = we; WriteAddr = wa; DataIn = d; ReadAddrA = ra; ReadAddrB = rb;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rem[i] = depth[i];
         for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
      end
      Reset = 1'b1;
      set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Reset three cycles, then release with a write attempted during the clear.
      repeat (3) cycle();
      chk("t1_busy_in_reset", 32'(busy0), 32'd1);
      chk("t1_douta_reset", 32'(a0), 32'd0);
      Reset = 1'b0;
      for (int k = 0; k < 256; k++) begin
         if (k == 0) set_in(1'b1, 8'h10, 8'h7B, 8'h10, 8'h10);
         else        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
         cycle();
         if (k == 0)   chk("t4_drop_busy", 32'(drop0), 32'd1);
         if (k == 1)   chk("t4_drop_clears", 32'(drop0), 32'd0);
         if (k == 254) chk("t1_busy_255", 32'(busy0), 32'd1);
      end
      chk("t1_busy_256", 32'(busy0), 32'd0);

      set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'd127); cycle();
      chk("t1_rd0", 32'(a0), 32'h00);
      chk("t1_rd127", 32'(b0), 32'h00);
      set_in(1'b0, 8'h00, 8'h00, 8'd255, 8'h10); cycle();
      chk("t1_rd255", 32'(a0), 32'h00);
      chk("t4_rd10", 32'(b0), 32'h00);

      // Two writes, then dual-port read.
      set_in(1'b1, 8'h00, 8'h52, 8'h00, 8'h00); cycle();
      set_in(1'b1, 8'h02, 8'hE6, 8'h00, 8'h00); cycle();
      set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h02); cycle();
      chk("t2_rdA", 32'(a0), 32'h52);
      chk("t2_rdB", 32'(b0), 32'hE6);
      set_in(1'b0, 8'h00, 8'h00, 8'h02, 8'h02); cycle();
      chk("t2_sameA", 32'(a0), 32'hE6);
      chk("t2_sameB", 32'(b0), 32'hE6);

      // Same-edge write and read of one address.
      set_in(1'b1, 8'h14, 8'h05, 8'h00, 8'h00); cycle();
      set_in(1'b1, 8'h14, 8'hA3, 8'h14, 8'h00); cycle();
      chk("t3_same_edge", 32'(a0), BYP ? 32'hA3 : 32'h05);
      set_in(1'b0, 8'h00, 8'h00, 8'h14, 8'h14); cycle();
      chk("t3_reread", 32'(a0), 32'hA3);

      // Address 201 is out of range only for the 200-word instance.
      set_in(1'b1, 8'd201, 8'hFF, 8'd201, 8'd201); cycle();
      chk("t6_drop200", 32'(drop1), 32'd1);
      chk("t6_nodrop256", 32'(drop0), 32'd0);
      chk("t6_nofwd200", 32'(a1), 32'h00);
      set_in(1'b0, 8'h00, 8'h00, 8'd201, 8'd199); cycle();
      chk("t6_rd201_200", 32'(a1), 32'h00);
      chk("t6_rd201_256", 32'(a0), 32'hFF);
      chk("t6_drop_pulse", 32'(drop1), 32'd0);

      // Write, reset, interrupt the clear at cycle 100 with a second reset.
      set_in(1'b1, 8'h40, 8'h4D, 8'h00, 8'h00); cycle();
      set_in(1'b0, 8'h00, 8'h00, 8'h40, 8'h00); cycle();
      chk("t5_rd40_before", 32'(a0), 32'h4D);
      Reset = 1'b1; cycle();
      Reset = 1'b0;
      repeat (100) cycle();
      Reset = 1'b1; cycle();
      Reset = 1'b0;
      for (int k = 0; k < 256; k++) begin
         cycle();
         if (k == 254) chk("t5_busy_255", 32'(busy0), 32'd1);
      end
      chk("t5_busy_256", 32'(busy0), 32'd0);
      set_in(1'b0, 8'h00, 8'h00, 8'h40, 8'h40); cycle();
      chk("t5_rd40_after", 32'(a0), 32'h00);

      // Random traffic with frequent address collisions.
      for (int k = 0; k < 800; k++) begin
         logic [7:0] wa;
         wa = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) wa = 8'($urandom_range(190, 210));
         set_in(1'($urandom_range(0, 1)), wa, 8'($urandom),
                ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(180, 255)));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
